// File: rtl/pc_exception_unit.sv
// Program counter of the multicycle MIPS core, with exception entry:
// saves EPC, fetches the handler address byte from memory and loads it into PC.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | normal operation; PC follows the unconditional/branch write rules
// SAVE  | read strobe and vector address are out this cycle; EPC <= PC - 4
// WAIT  | waiting out the remaining memory read latency
// LOAD  | handler byte is on mem_rdata; PC <= {24'b0, mem_rdata}
module pc_exception_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] OVF_VEC  = 32'd255,
    parameter logic [31:0] OPC_VEC  = 32'd254,
    parameter int          MEM_LAT  = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] next_pc,
    input  logic        pc_write,
    input  logic        pc_write_cond,
    input  logic        branch_ne,
    input  logic        alu_zero,
    input  logic        exc_ovf,
    input  logic        exc_opcode,
    input  logic [7:0]  mem_rdata,
    output logic [31:0] pc,
    output logic [31:0] epc,
    output logic        exc_busy,
    output logic        exc_mem_rd,
    output logic [31:0] exc_mem_addr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SAVE = 2'd1,
        S_WAIT = 2'd2,
        S_LOAD = 2'd3
    } state_t;

    // Down-counter start so WAIT lasts MEM_LAT-1 cycles (terminal count 0).
    localparam logic [2:0] WAIT_LOAD = (MEM_LAT >= 2) ? 3'(MEM_LAT - 2) : 3'd0;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] epc_q, epc_d;
    logic [2:0]  wait_cnt_q, wait_cnt_d;
    logic        mem_rd_q, mem_rd_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        take;

    assign take = pc_write | (pc_write_cond & (alu_zero ^ branch_ne));

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        epc_d      = epc_q;
        wait_cnt_d = wait_cnt_q;
        mem_rd_d   = 1'b0;
        mem_addr_d = 32'd0;

        case (state_q)
            S_IDLE: begin
                // The strobe is registered, so it is launched on the entry edge
                // and is visible for exactly the SAVE cycle.
                if (exc_ovf | exc_opcode) begin
                    state_d    = S_SAVE;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = exc_ovf ? OVF_VEC : OPC_VEC;
                end else if (take) begin
                    pc_d = next_pc;
                end
            end
            S_SAVE: begin
                epc_d = pc_q - 32'd4;
                if (MEM_LAT > 1) begin
                    state_d    = S_WAIT;
                    wait_cnt_d = WAIT_LOAD;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == 3'd0) begin
                    state_d = S_LOAD;
                end else begin
                    wait_cnt_d = wait_cnt_q - 3'd1;
                end
            end
            S_LOAD: begin
                pc_d    = {24'd0, mem_rdata};
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            epc_q      <= 32'd0;
            wait_cnt_q <= 3'd0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            wait_cnt_q <= wait_cnt_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign pc           = pc_q;
    assign epc          = epc_q;
    assign exc_busy     = (state_q != S_IDLE);
    assign exc_mem_rd   = mem_rd_q;
    assign exc_mem_addr = mem_addr_q;

endmodule

// File: tb/tb_pc_exception_unit.sv
// Self-checking bench for pc_exception_unit: PC write rules, exception entry
// sequence, priority, busy masking and asynchronous reset.
module tb_pc_exception_unit;

    localparam int MEM_LAT = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] next_pc;
    logic        pc_write, pc_write_cond, branch_ne, alu_zero;
    logic        exc_ovf, exc_opcode;
    logic [7:0]  mem_rdata;
    logic [31:0] pc, epc, exc_mem_addr;
    logic        exc_busy, exc_mem_rd;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] epc;
        logic [31:0] addr;
        logic [31:0] pc;
    } exp_t;
    exp_t exp_q[$];

    logic [7:0] mem_byte = 8'h00;
    bit         pend = 1'b0;
    int         lat_cnt = 0;

    pc_exception_unit #(.MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .reset_n(reset_n), .next_pc(next_pc),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .branch_ne(branch_ne), .alu_zero(alu_zero),
        .exc_ovf(exc_ovf), .exc_opcode(exc_opcode), .mem_rdata(mem_rdata),
        .pc(pc), .epc(epc), .exc_busy(exc_busy),
        .exc_mem_rd(exc_mem_rd), .exc_mem_addr(exc_mem_addr)
    );

    always #5 clk = ~clk;

    // Memory: the byte is valid only in the cycle MEM_LAT after the strobe.
    always @(negedge clk) begin
        mem_rdata = 8'hEE;
        if (!reset_n) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                lat_cnt = lat_cnt - 1;
                if (lat_cnt == 0) begin
                    mem_rdata = mem_byte;
                    pend = 1'b0;
                end
            end
            if (exc_mem_rd) begin
                pend = 1'b1;
                lat_cnt = MEM_LAT;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    task automatic do_exc(input logic ovf, input logic opc, input logic [7:0] byte_v,
                          input logic [31:0] cur_pc, input logic hold_pcw,
                          input logic pulse_busy, input string tag);
        exp_t e;
        exp_t got;
        int busy_cnt = 0;
        int rd_cnt = 0;
        logic [31:0] rd_addr = 32'd0;
        bit early = 1'b0;
        bit done = 1'b0;
        e.epc  = cur_pc - 32'd4;
        e.addr = ovf ? 32'd255 : 32'd254;
        e.pc   = {24'd0, byte_v};
        exp_q.push_back(e);
        mem_byte   = byte_v;
        exc_ovf    = ovf;
        exc_opcode = opc;
        pc_write   = hold_pcw;
        next_pc    = 32'hDEAD_BEE0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            exc_ovf = 1'b0;
            exc_opcode = 1'b0;
            if (exc_mem_rd) begin
                rd_cnt++;
                rd_addr = exc_mem_addr;
            end
            if (exc_busy) begin
                busy_cnt++;
                if (pc !== cur_pc) early = 1'b1;
                if (pulse_busy && busy_cnt >= 2) exc_opcode = 1'b1;
            end else begin
                done = 1'b1;
            end
        end
        pc_write = 1'b0;
        n_vec++;
        if (!done) begin
            n_err++;
            $display("FAIL %s busy_timeout: busy cycles got %0d want 3", tag, busy_cnt);
        end
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s scoreboard_empty: queue size got 0 want 1", tag);
        end else begin
            got = exp_q.pop_front();
            n_vec++;
            if (epc !== got.epc) begin
                n_err++;
                $display("FAIL %s epc: got %h want %h", tag, epc, got.epc);
            end
            n_vec++;
            if (rd_addr !== got.addr) begin
                n_err++;
                $display("FAIL %s vec_addr: got %0d want %0d", tag, rd_addr, got.addr);
            end
            n_vec++;
            if (pc !== got.pc) begin
                n_err++;
                $display("FAIL %s handler_pc: got %h want %h", tag, pc, got.pc);
            end
        end
        n_vec++;
        if (rd_cnt != 1) begin
            n_err++;
            $display("FAIL %s rd_pulses: got %0d want 1", tag, rd_cnt);
        end
        n_vec++;
        if (busy_cnt != 3) begin
            n_err++;
            $display("FAIL %s busy_cycles: got %0d want 3", tag, busy_cnt);
        end
        n_vec++;
        if (early) begin
            n_err++;
            $display("FAIL %s pc_stable_while_busy: got changed want %h", tag, cur_pc);
        end
        if (pulse_busy) begin
            @(negedge clk);
            n_vec++;
            if (exc_busy !== 1'b0 || exc_mem_rd !== 1'b0) begin
                n_err++;
                $display("FAIL %s no_reentry: busy/rd got %b%b want 00", tag, exc_busy, exc_mem_rd);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        pc_write = 1'b1; pc_write_cond = 1'b0; branch_ne = 1'b0; alu_zero = 1'b0;
        exc_ovf = 1'b0; exc_opcode = 1'b0; next_pc = 32'h40;
        repeat (2) @(negedge clk);
        n_vec++;
        if (pc !== 32'h0 || epc !== 32'h0) begin
            n_err++;
            $display("FAIL reset_regs: pc/epc got %h/%h want 0/0", pc, epc);
        end
        n_vec++;
        if (exc_busy !== 1'b0 || exc_mem_rd !== 1'b0 || exc_mem_addr !== 32'h0) begin
            n_err++;
            $display("FAIL reset_ctrl: busy/rd/addr got %b/%b/%h want 0/0/0", exc_busy, exc_mem_rd, exc_mem_addr);
        end
        reset_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (pc !== 32'h40) begin
            n_err++;
            $display("FAIL reset_release_pc: got %h want %h", pc, 32'h40);
        end
        pc_write = 1'b0;
    endtask

    task automatic test_branch();
        logic [31:0] nxt [6] = '{32'h100, 32'h200, 32'h300, 32'h400, 32'h500, 32'h600};
        logic        cnd [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic        zro [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic        bne [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] model = 32'h40;
        for (int i = 0; i < 6; i++) begin
            next_pc = nxt[i]; pc_write_cond = cnd[i]; alu_zero = zro[i]; branch_ne = bne[i];
            if (cnd[i] && (zro[i] ^ bne[i])) model = nxt[i];
            @(negedge clk);
            n_vec++;
            if (pc !== model) begin
                n_err++;
                $display("FAIL branch_%0d: pc got %h want %h", i, pc, model);
            end
        end
        pc_write_cond = 1'b0; alu_zero = 1'b0; branch_ne = 1'b0;
    endtask

    task automatic test_overflow();
        next_pc = 32'h10; pc_write = 1'b1;
        @(negedge clk);
        pc_write = 1'b0;
        n_vec++;
        if (pc !== 32'h10) begin
            n_err++;
            $display("FAIL ovf_setup_pc: got %h want %h", pc, 32'h10);
        end
        do_exc(1'b1, 1'b0, 8'h80, 32'h10, 1'b0, 1'b0, "overflow");
    endtask

    task automatic test_priority_and_mask();
        do_exc(1'b1, 1'b1, 8'h44, 32'h80, 1'b0, 1'b0, "both_exc");
        do_exc(1'b0, 1'b1, 8'h20, 32'h44, 1'b0, 1'b1, "opc_masked");
    endtask

    task automatic test_back_to_back();
        do_exc(1'b1, 1'b0, 8'h60, 32'h20, 1'b0, 1'b0, "b2b_first");
        do_exc(1'b0, 1'b1, 8'h70, 32'h60, 1'b0, 1'b0, "b2b_second");
    endtask

    task automatic test_reset_in_wait();
        mem_byte = 8'h99;
        exc_ovf = 1'b1;
        @(negedge clk);
        exc_ovf = 1'b0;
        @(negedge clk);
        n_vec++;
        if (exc_busy !== 1'b1) begin
            n_err++;
            $display("FAIL rst_wait_busy: got %b want 1", exc_busy);
        end
        #2 reset_n = 1'b0;
        #1;
        n_vec++;
        if (pc !== 32'h0 || epc !== 32'h0) begin
            n_err++;
            $display("FAIL rst_wait_regs: pc/epc got %h/%h want 0/0", pc, epc);
        end
        n_vec++;
        if (exc_busy !== 1'b0 || exc_mem_rd !== 1'b0 || exc_mem_addr !== 32'h0) begin
            n_err++;
            $display("FAIL rst_wait_ctrl: busy/rd/addr got %b/%b/%h want 0/0/0", exc_busy, exc_mem_rd, exc_mem_addr);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (exc_busy !== 1'b0 || pc !== 32'h0) begin
            n_err++;
            $display("FAIL rst_wait_after: busy/pc got %b/%h want 0/0", exc_busy, pc);
        end
        do_exc(1'b0, 1'b1, 8'h33, 32'h0, 1'b0, 1'b0, "after_reset");
    endtask

    task automatic test_pc_zero_hold();
        next_pc = 32'h0; pc_write = 1'b1;
        @(negedge clk);
        pc_write = 1'b0;
        n_vec++;
        if (pc !== 32'h0) begin
            n_err++;
            $display("FAIL pc0_setup: got %h want 0", pc);
        end
        do_exc(1'b1, 1'b0, 8'h5A, 32'h0, 1'b1, 1'b0, "pc0_hold");
    endtask

    initial begin
        mem_rdata = 8'hEE;
        test_reset();
        test_branch();
        test_overflow();
        test_priority_and_mask();
        test_back_to_back();
        test_reset_in_wait();
        test_pc_zero_hold();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
